// File: rtl/ct_f_spsram_cfg_pkg.sv
// Shared types and defaults for the configurable FPGA single-port SRAM wrapper.
package ct_f_spsram_cfg_pkg;

    localparam int DEF_WRAP_SIZE = 27;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_INIT  = 2'b01,
        ST_READY = 2'b10
    } init_state_e;

    function automatic int num_bank(input int data_width, input int wrap_size);
        return data_width / wrap_size;
    endfunction

endpackage

// File: rtl/ct_f_sram_init_ctrl.sv
// Post-reset zero-fill sequencer; owns the bank address/data/write muxes while sweeping.
module ct_f_sram_init_ctrl
    import ct_f_spsram_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 54,
    parameter int NUM_BANK   = 2,
    parameter int INIT_EN    = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [NUM_BANK-1:0]   ext_we,
    input  logic [DATA_WIDTH-1:0] ext_din,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [NUM_BANK-1:0]   ram_we,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ready,
    output logic                  INIT_BUSY
);

    init_state_e           state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  sweeping;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                cnt_nxt   = '0;
                state_nxt = (INIT_EN != 0) ? ST_INIT : ST_READY;
            end
            ST_INIT: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == {ADDR_WIDTH{1'b1}}) state_nxt = ST_READY;
            end
            ST_READY: state_nxt = ST_READY;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // External traffic only reaches the banks once the sweep has finished.
    assign sweeping  = (state == ST_INIT);
    assign ready     = (state == ST_READY);
    assign ram_addr  = sweeping ? cnt : ext_addr;
    assign ram_we    = sweeping ? {NUM_BANK{1'b1}} : (ready ? ext_we : '0);
    assign ram_din   = sweeping ? '0 : ext_din;
    assign INIT_BUSY = (INIT_EN != 0) && !ready;

endmodule

// File: rtl/fpga_ram.sv
// Single FPGA block-RAM bank: synchronous read, write-first on a write cycle.
module fpga_ram #(
    parameter int WIDTH      = 27,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  CLK,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  WE,
    input  logic [WIDTH-1:0]      D,
    output logic [WIDTH-1:0]      Q
);

    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge CLK) begin
        if (WE) begin
            mem[A] <= D;
            Q      <= D;
        end else begin
            Q <= mem[A];
        end
    end

endmodule

// File: rtl/ct_f_spsram_cfg.sv
// Parametrised single-port SRAM built from fpga_ram banks, with optional
// output register and hardware zero-fill after reset.
module ct_f_spsram_cfg
    import ct_f_spsram_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 54,
    parameter int WRAP_SIZE  = DEF_WRAP_SIZE,
    parameter int OUT_REG    = 0,
    parameter int INIT_EN    = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  INIT_BUSY
);

    localparam int NUM_BANK = num_bank(DATA_WIDTH, WRAP_SIZE);

    if (DATA_WIDTH % WRAP_SIZE != 0) begin : g_bad_split
        $error("ct_f_spsram_cfg: DATA_WIDTH must be a multiple of WRAP_SIZE");
    end

    logic [ADDR_WIDTH-1:0] addr_holding;
    logic [ADDR_WIDTH-1:0] ext_addr, ram_addr;
    logic [NUM_BANK-1:0]   ext_we, ram_we;
    logic [DATA_WIDTH-1:0] ram_din, bank_q;
    logic                  ready;
    logic                  unused_wen_bits;

    // Only the top bit of each bank's WEN slice participates.
    assign unused_wen_bits = ^WEN;
    assign ext_addr        = CEN ? addr_holding : A;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                addr_holding <= '0;
        else if (ready && !CEN) addr_holding <= A;
    end

    ct_f_sram_init_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_BANK   (NUM_BANK),
        .INIT_EN    (INIT_EN)
    ) u_init_ctrl (
        .CLK       (CLK),
        .RST       (RST),
        .ext_addr  (ext_addr),
        .ext_we    (ext_we),
        .ext_din   (D),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ready     (ready),
        .INIT_BUSY (INIT_BUSY)
    );

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        assign ext_we[b] = !CEN && !GWEN && !WEN[(b+1)*WRAP_SIZE-1];

        fpga_ram #(
            .WIDTH      (WRAP_SIZE),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_ram (
            .CLK (CLK),
            .A   (ram_addr),
            .WE  (ram_we[b]),
            .D   (ram_din[b*WRAP_SIZE +: WRAP_SIZE]),
            .Q   (bank_q[b*WRAP_SIZE +: WRAP_SIZE])
        );
    end

    // Stage p1: optional output register, loaded unconditionally every cycle.
    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] q_p1;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) q_p1 <= '0;
            else     q_p1 <= bank_q;
        end

        assign Q = q_p1;
    end else begin : g_out_comb
        assign Q = bank_q;
    end

endmodule
